// File: rtl/online_pkg.sv
// Shared types and constants for the radix-2 online residual/digit-select block.
package online_pkg;

   localparam int unsigned RES_W = 18;

   typedef enum logic {IDLE, ITER} state_t;

   typedef struct packed {
      logic p;
      logic n;
   } sdigit_t;

   localparam logic signed [3:0] EST_POS = 4'sd2;
   localparam logic signed [3:0] EST_NEG = -4'sd3;

   // est is in units of 1/4: +1 at est >= 1/2, -1 at est <= -3/4
   function automatic sdigit_t select_digit(input logic signed [3:0] est);
      sdigit_t d;
      d = '0;
      if (est >= EST_POS)
         d.p = 1'b1;
      else if (est <= EST_NEG)
         d.n = 1'b1;
      return d;
   endfunction

endpackage

// File: rtl/online_residual_select_otfc_conv.sv
// On-the-fly conversion (Q/QM) of the signed-digit stream; present only when
// ONLINE_OTFC_EN is defined.
`ifdef ONLINE_OTFC_EN
module otfc_conv #(
   parameter int unsigned NDIG = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   input  logic            dig_p,
   input  logic            dig_n,
   output logic [NDIG-1:0] q
);

   logic [NDIG-1:0] r_q;
   logic [NDIG-1:0] r_qm;

   // r_qm tracks r_q - 1 over the digits seen so far
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_q  <= '0;
         r_qm <= '0;
      end else if (en) begin
         if (dig_p) begin
            r_q  <= {r_q[NDIG-2:0], 1'b1};
            r_qm <= {r_q[NDIG-2:0], 1'b0};
         end else if (dig_n) begin
            r_q  <= {r_qm[NDIG-2:0], 1'b1};
            r_qm <= {r_qm[NDIG-2:0], 1'b0};
         end else begin
            r_q  <= {r_q[NDIG-2:0], 1'b0};
            r_qm <= {r_qm[NDIG-2:0], 1'b1};
         end
      end
   end

   assign q = r_q;

endmodule
`endif

// File: rtl/online_residual_select.sv
// Radix-2 online iteration controller: residual register, digit selection and
// shifted carry-save feedback. Optional ONLINE_OTFC_EN adds Q/QM result conversion.
module online_residual_select
   import online_pkg::*;
#(
   parameter int unsigned W     = RES_W,
   parameter int unsigned NDIG  = 16,
   parameter int unsigned DELTA = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [W-1:0]    ws_in,
   input  logic [W-1:0]    wc_in,
   output logic [W-1:0]    ws_fb,
   output logic [W-1:0]    wc_fb,
   output logic            busy,
   output logic            digit_valid,
   output logic            digit_p,
   output logic            digit_n,
   output logic            done,
   output logic [NDIG-1:0] result
);

   localparam int unsigned NITER = DELTA + NDIG;
   localparam int unsigned CW    = $clog2(NITER);
   localparam int unsigned LAST  = NITER - 1;

   state_t            r_state;
   logic [CW-1:0]     r_count;

   logic signed [3:0] w_est;
   sdigit_t           w_sel;
   sdigit_t           w_z;
   logic              w_sel_en;
   logic              w_t0;
   logic              w_start_acc;

   assign w_est    = $signed(ws_in[W-1:W-4] + wc_in[W-1:W-4]);
   assign w_sel_en = (r_count >= CW'(DELTA));
   assign w_sel    = select_digit(w_est);
   assign w_z      = w_sel_en ? w_sel : '0;

   // Only bit 0 of (top2 sum - z) mod 4 survives the shift; subtracting +-1 just flips it.
   assign w_t0 = ws_in[W-2] ^ wc_in[W-2] ^ (w_z.p | w_z.n);

   // The done cycle is already IDLE; holding off there leaves one idle cycle before restart.
   assign w_start_acc = (r_state == IDLE) && start && !done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_count     <= '0;
         ws_fb       <= '0;
         wc_fb       <= '0;
         busy        <= 1'b0;
         digit_valid <= 1'b0;
         digit_p     <= 1'b0;
         digit_n     <= 1'b0;
         done        <= 1'b0;
      end else begin
         digit_valid <= 1'b0;
         digit_p     <= 1'b0;
         digit_n     <= 1'b0;
         done        <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_acc) begin
                  ws_fb   <= '0;
                  wc_fb   <= '0;
                  r_count <= '0;
                  busy    <= 1'b1;
                  r_state <= ITER;
               end
            end
            ITER: begin
               ws_fb       <= {w_t0, ws_in[W-3:0], 1'b0};
               wc_fb       <= {1'b0, wc_in[W-3:0], 1'b0};
               digit_valid <= w_sel_en;
               digit_p     <= w_z.p;
               digit_n     <= w_z.n;
               if (r_count == CW'(LAST)) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ONLINE_OTFC_EN
   logic w_dig_en;
   assign w_dig_en = (r_state == ITER) && w_sel_en;

   otfc_conv #(
      .NDIG(NDIG)
   ) u_otfc (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_start_acc),
      .en   (w_dig_en),
      .dig_p(w_z.p),
      .dig_n(w_z.n),
      .q    (result)
   );
`else
   assign result = '0;
`endif

endmodule
